dot_max_engine: RTL and testbench
=================================

Name: dot_max_engine

Overview:
Parametrised successor to the fixed 4-lane byte dot-product/max tracker. Operand vectors are shifted in one element per cycle into a weight bank and an input bank. On a start command, one lane per cycle is multiply-accumulated (signed or unsigned), and the running maximum is updated. Results and max are presented full-width with done/update pulses. Sits between the tile's byte-wide load interface and its output mux.

Parameters:
DATA_W, 8, operand element width in bits
LANES, 4, elements per vector (>=1)
SIGNED, 0, 1 = two's-complement operands and compare; 0 = unsigned
ACC_W (localparam), 2*DATA_W+$clog2(LANES)+1, accumulator/result/max width; overflow impossible

Ports:
clk  in  1  clock, all state rising-edge
rst_n  in  1  asynchronous active-low reset
load_data  in  DATA_W  element to shift in
load_valid  in  1  shift load_data into bank chosen by load_sel this cycle
load_sel  in  1  1 = weight bank, 0 = input bank
start  in  1  begin dot product (accepted in IDLE only)
clear_max  in  1  reset running max to floor value
busy  out  1  FSM not IDLE
done  out  1  one-cycle pulse, result valid
result  out  ACC_W  last dot product, held until next done
max_value  out  ACC_W  running maximum
max_new  out  1  one-cycle pulse, coincident with done, when max_value updated

Behaviour:
- Reset (async assert, sync-released use): both banks 0, FSM IDLE, accumulator 0, result 0, max_value 0, busy/done/max_new 0.
- Load: when load_valid and not busy, selected bank shifts: lane LANES-1 <= load_data, lane k <= lane k+1. After LANES loads, first element is in lane 0. load_valid while busy is ignored (banks frozen, no snapshot needed).
- FSM: IDLE -> MAC on start. MAC runs exactly LANES cycles, lane index 0..LANES-1, acc <= acc + ext(w[i])*ext(x[i]) (acc cleared on entry). MAC -> DONE. DONE lasts 1 cycle: result <= acc, done=1, max compare, then -> IDLE.
- Latency: start sampled at edge t -> done high in cycle after edge t+LANES+1; busy high from edge t until the DONE edge. start during busy ignored; back-to-back start accepted in the first IDLE cycle after DONE.
- Extension: SIGNED=1 sign-extends operands and products to ACC_W, compares signed; SIGNED=0 zero-extends, compares unsigned.
- Max: update only if result strictly greater than max_value; ties do not update, no max_new.
- clear_max: max_value <= floor (0 unsigned; -2^(ACC_W-1) signed). Permitted any cycle. Coincident with DONE: clear applied first, then compare, so max_value = result, max_new=1.
- Reset mid-MAC: abort immediately, no done, all outputs to reset values.
- Registered outputs only; no combinational in-to-out paths.

Decomposition:
- Package dot_max_pkg: FSM state enum (IDLE, MAC, DONE), LOAD_SEL_WEIGHT/LOAD_SEL_INPUT constants, acc-width helper function.
- One sub-module: dot_max_mac_lane (operand extension, multiply, accumulate register, clear/enable), parametrised by DATA_W, ACC_W, SIGNED.

Test Plan:
- Defaults; load weights 1,2,3,4 then inputs 5,6,7,8; start -> done exactly 5 cycles after start edge, result=70, max_value=70, max_new=1.
- Then inputs 1,1,1,1 -> result=10, max stays 70, max_new=0. Reload 5,6,7,8 -> result=70, tie, max_new=0.
- All elements 255 -> result=260100 (0x3F804), max_value=260100, max_new=1.
- SIGNED=1: all weights and inputs -128 -> result=65536. Then clear_max -> max_value=-2^(ACC_W-1). Then weights -1, inputs 1 -> result=-4, max_value=-4, max_new=1.
- Assert rst_n low on 2nd MAC cycle -> busy=0, no done pulse, result=0, max_value=0. start and load_valid while busy -> ignored, banks and result unchanged.
- clear_max in the DONE cycle with max=70, result=10 -> max_value=10, max_new=1.

Source files
------------

// File: rtl/dot_max_pkg.sv
// Shared types and constants for the dot-product / running-max engine.
// The accumulator width is sized so LANES full-scale products cannot overflow.
package dot_max_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DONE
  } state_e;

  localparam logic LOAD_SEL_WEIGHT = 1'b1;
  localparam logic LOAD_SEL_INPUT  = 1'b0;

  function automatic int acc_width(input int data_w, input int lanes);
    return 2 * data_w + $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/dot_max_mac_lane.sv
// Single multiply-accumulate datapath: extends both operands to the accumulator
// width, multiplies, and accumulates under clear/enable control.
module dot_max_mac_lane #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] x,
  output logic [ACC_W-1:0]  acc
);

  logic             w_fill;
  logic             x_fill;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] prod;

  assign w_fill = (SIGNED != 0) && w[DATA_W-1];
  assign x_fill = (SIGNED != 0) && x[DATA_W-1];
  assign w_ext  = {{(ACC_W-DATA_W){w_fill}}, w};
  assign x_ext  = {{(ACC_W-DATA_W){x_fill}}, x};
  // Truncated ACC_W product is exact in two's complement for both modes.
  assign prod   = w_ext * x_ext;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod;
    end
  end

endmodule

// File: rtl/dot_max_engine.sv
// Shift-loaded weight/input banks, one-lane-per-cycle dot product and a
// running-maximum tracker with clear, all outputs registered.
module dot_max_engine
  import dot_max_pkg::*;
#(
  parameter int   DATA_W = 8,
  parameter int   LANES  = 4,
  parameter int   SIGNED = 0,
  localparam int  ACC_W  = acc_width(DATA_W, LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  input  logic              load_sel,
  input  logic              start,
  input  logic              clear_max,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic [ACC_W-1:0]  max_value,
  output logic              max_new
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ACC_W-1:0] MAX_FLOOR =
    (SIGNED != 0) ? {1'b1, {(ACC_W-1){1'b0}}} : '0;

  state_e            state;
  state_e            state_next;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] w_bank [LANES];
  logic [DATA_W-1:0] x_bank [LANES];
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  max_base;
  logic              acc_gt;

  // NOTE: the banks are small register arrays and are reset explicitly; a RAM macro would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        w_bank[k] <= '0;
        x_bank[k] <= '0;
      end
    end else if (load_valid && state == ST_IDLE) begin
      if (load_sel == LOAD_SEL_WEIGHT) begin
        for (int k = 0; k < LANES - 1; k++) w_bank[k] <= w_bank[k+1];
        w_bank[LANES-1] <= load_data;
      end else if (load_sel == LOAD_SEL_INPUT) begin
        for (int k = 0; k < LANES - 1; k++) x_bank[k] <= x_bank[k+1];
        x_bank[LANES-1] <= load_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_MAC) idx <= idx + 1'b1;
      else                 idx <= '0;
    end
  end

  // NOTE: defaults come first so no path through this block infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_MAC;
      ST_MAC:  if (idx == IDX_W'(LANES - 1)) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  dot_max_mac_lane #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac_lane (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == ST_IDLE && start),
    .en    (state == ST_MAC),
    .w     (w_bank[idx]),
    .x     (x_bank[idx]),
    .acc   (acc)
  );

  // A clear coincident with DONE is applied before the compare.
  always_comb begin
    max_base = clear_max ? MAX_FLOOR : max_value;
    if (SIGNED != 0) acc_gt = $signed(acc) > $signed(max_base);
    else             acc_gt = acc > max_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      max_new   <= 1'b0;
      result    <= '0;
      max_value <= '0;
    end else begin
      done    <= (state == ST_DONE);
      max_new <= 1'b0;
      if (state == ST_DONE) begin
        result <= acc;
        if (acc_gt) begin
          max_value <= acc;
          max_new   <= 1'b1;
        end else begin
          max_value <= max_base;
        end
      end else begin
        max_value <= max_base;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_dot_max_engine.sv
// Bench for dot_max_engine: unsigned and signed instances share one stimulus
// stream and are compared against an arithmetic model of banks and maximum.
module tb_dot_max_engine;

  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int ACC_W  = 2 * DATA_W + $clog2(LANES) + 1;
  localparam int FLOOR_S = -(1 << (ACC_W - 1));

  typedef logic [ACC_W-1:0] acc_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] load_data;
  logic              load_valid;
  logic              load_sel;
  logic              start;
  logic              clear_max;

  logic u_busy, u_done, u_new;
  logic s_busy, s_done, s_new;
  acc_t u_result, u_max, s_result, s_max;

  int tests_run    = 0;
  int tests_failed = 0;

  int w_q[$];
  int x_q[$];
  int mu;
  int ms;

  always #5 clk = ~clk;

  dot_max_engine #(.DATA_W(DATA_W), .LANES(LANES), .SIGNED(0)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_sel   (load_sel),
    .start      (start),
    .clear_max  (clear_max),
    .busy       (u_busy),
    .done       (u_done),
    .result     (u_result),
    .max_value  (u_max),
    .max_new    (u_new)
  );

  dot_max_engine #(.DATA_W(DATA_W), .LANES(LANES), .SIGNED(1)) s_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_sel   (load_sel),
    .start      (start),
    .clear_max  (clear_max),
    .busy       (s_busy),
    .done       (s_done),
    .result     (s_result),
    .max_value  (s_max),
    .max_new    (s_new)
  );

  function automatic int ext8(input int v, input bit sgn);
    return (sgn && v >= 128) ? v - 256 : v;
  endfunction

  function automatic int model_dot(input bit sgn);
    int s = 0;
    for (int i = 0; i < LANES; i++) s += ext8(w_q[i], sgn) * ext8(x_q[i], sgn);
    return s;
  endfunction

  task automatic model_reset();
    w_q = {};
    x_q = {};
    for (int i = 0; i < LANES; i++) begin
      w_q.push_back(0);
      x_q.push_back(0);
    end
    mu = 0;
    ms = 0;
  endtask

  task automatic load_vec(input bit sel, input int v[LANES]);
    for (int i = 0; i < LANES; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_sel   = sel;
      load_data  = DATA_W'(v[i]);
      if (sel) begin w_q.push_back(v[i] & 255); void'(w_q.pop_front()); end
      else     begin x_q.push_back(v[i] & 255); void'(x_q.pop_front()); end
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_data = '0; load_valid = 1'b0; load_sel = 1'b0;
    start = 1'b0; clear_max = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({u_busy, u_done, u_new, s_busy, s_done, s_new} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b required 000000", {u_busy, u_done, u_new, s_busy, s_done, s_new});
    end
    tests_run++;
    if ({u_result, u_max, s_result, s_max} !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: got %h %h %h %h required all 0", u_result, u_max, s_result, s_max);
    end
    rst_n = 1'b1;
  endtask

  // One dot product; optional clear_max in the DONE cycle and optional
  // start/load noise while busy (must be ignored).
  task automatic run_dot(input string name, input bit clr, input bit noise);
    int   dot_u, dot_s, first_done, u_cnt, s_cnt;
    bit   exp_nu, exp_ns, got_nu, got_ns;
    dot_u = model_dot(1'b0);
    dot_s = model_dot(1'b1);
    if (clr) begin mu = 0; ms = FLOOR_S; end
    exp_nu = dot_u > mu; if (exp_nu) mu = dot_u;
    exp_ns = dot_s > ms; if (exp_ns) ms = dot_s;

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    tests_run++;
    if (u_busy !== 1'b1 || s_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_busy: got %b/%b required 1/1", name, u_busy, s_busy);
    end
    first_done = -1; u_cnt = 0; s_cnt = 0; got_nu = 0; got_ns = 0;
    for (int n = 1; n <= LANES + 4; n++) begin
      if (noise && n == 2) begin
        start = 1'b1; load_valid = 1'b1;
        load_sel = 1'($urandom_range(0, 1)); load_data = DATA_W'($urandom);
      end
      if (noise && n == 3) begin start = 1'b0; load_valid = 1'b0; end
      if (clr && n == LANES + 1) clear_max = 1'b1;
      if (clr && n == LANES + 2) clear_max = 1'b0;
      @(negedge clk);
      if (u_done) begin
        u_cnt++;
        if (first_done < 0) begin first_done = n; got_nu = u_new; got_ns = s_new; end
      end
      if (s_done) s_cnt++;
    end
    tests_run++;
    if (first_done != LANES + 1 || u_cnt != 1 || s_cnt != 1) begin
      tests_failed++;
      $display("FAIL %s_latency: got cycle %0d pulses %0d/%0d required cycle %0d pulses 1/1",
               name, first_done, u_cnt, s_cnt, LANES + 1);
    end
    tests_run++;
    if (u_result !== acc_t'(dot_u) || s_result !== acc_t'(dot_s)) begin
      tests_failed++;
      $display("FAIL %s_result: got %h/%h required %h/%h", name, u_result, s_result,
               acc_t'(dot_u), acc_t'(dot_s));
    end
    tests_run++;
    if (u_max !== acc_t'(mu) || s_max !== acc_t'(ms)) begin
      tests_failed++;
      $display("FAIL %s_max: got %h/%h required %h/%h", name, u_max, s_max, acc_t'(mu), acc_t'(ms));
    end
    tests_run++;
    if (got_nu !== exp_nu || got_ns !== exp_ns) begin
      tests_failed++;
      $display("FAIL %s_max_new: got %b/%b required %b/%b", name, got_nu, got_ns, exp_nu, exp_ns);
    end
    tests_run++;
    if (u_busy !== 1'b0 || s_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_idle: got busy %b/%b required 0/0", name, u_busy, s_busy);
    end
  endtask

  task automatic test_directed();
    load_vec(1'b1, '{1, 2, 3, 4});
    load_vec(1'b0, '{5, 6, 7, 8});
    run_dot("dot70", 1'b0, 1'b0);
    load_vec(1'b0, '{1, 1, 1, 1});
    run_dot("dot10", 1'b0, 1'b0);
    load_vec(1'b0, '{5, 6, 7, 8});
    run_dot("tie70", 1'b0, 1'b1);
    load_vec(1'b0, '{1, 1, 1, 1});
    run_dot("clr_at_done", 1'b1, 1'b0);
    load_vec(1'b1, '{255, 255, 255, 255});
    load_vec(1'b0, '{255, 255, 255, 255});
    run_dot("all255", 1'b0, 1'b0);
    load_vec(1'b1, '{128, 128, 128, 128});
    load_vec(1'b0, '{128, 128, 128, 128});
    run_dot("neg128", 1'b0, 1'b0);
  endtask

  task automatic test_clear_max();
    @(negedge clk); clear_max = 1'b1;
    @(negedge clk); clear_max = 1'b0;
    mu = 0; ms = FLOOR_S;
    tests_run++;
    if (u_max !== acc_t'(0) || s_max !== acc_t'(FLOOR_S)) begin
      tests_failed++;
      $display("FAIL clear_max: got %h/%h required %h/%h", u_max, s_max, acc_t'(0), acc_t'(FLOOR_S));
    end
    load_vec(1'b1, '{255, 255, 255, 255});
    load_vec(1'b0, '{1, 1, 1, 1});
    run_dot("minus4", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int dot_u, dot_s, cnt, pos0, pos1;
    dot_u = model_dot(1'b0);
    dot_s = model_dot(1'b1);
    if (dot_u > mu) mu = dot_u;
    if (dot_s > ms) ms = dot_s;
    cnt = 0; pos0 = -1; pos1 = -1;
    @(negedge clk); start = 1'b1;
    for (int n = 0; n <= 3 * LANES; n++) begin
      if (n == LANES + 3) start = 1'b0;
      @(negedge clk);
      if (u_done && s_done) begin
        if (cnt == 0) pos0 = n; else pos1 = n;
        cnt++;
      end
    end
    tests_run++;
    if (cnt != 2 || pos0 != LANES + 1 || pos1 != 2 * LANES + 3) begin
      tests_failed++;
      $display("FAIL back_to_back: got %0d pulses at %0d,%0d required 2 at %0d,%0d",
               cnt, pos0, pos1, LANES + 1, 2 * LANES + 3);
    end
    tests_run++;
    if (u_result !== acc_t'(dot_u) || s_result !== acc_t'(dot_s) ||
        u_max !== acc_t'(mu) || s_max !== acc_t'(ms)) begin
      tests_failed++;
      $display("FAIL back_to_back_values: got %h/%h max %h/%h required %h/%h max %h/%h",
               u_result, s_result, u_max, s_max, acc_t'(dot_u), acc_t'(dot_s), acc_t'(mu), acc_t'(ms));
    end
  endtask

  task automatic test_random();
    int wv[LANES];
    int xv[LANES];
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < LANES; i++) begin
        wv[i] = int'($urandom_range(0, 255));
        xv[i] = int'($urandom_range(0, 255));
      end
      load_vec(1'b1, wv);
      load_vec(1'b0, xv);
      run_dot("random", ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end
  endtask

  task automatic test_reset_mid_mac();
    int dones;
    load_vec(1'b1, '{9, 9, 9, 9});
    load_vec(1'b0, '{9, 9, 9, 9});
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if ({u_busy, u_done, s_busy, s_done} !== 4'b0 || {u_result, u_max, s_result, s_max} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_mac: got busy %b/%b done %b/%b result %h/%h max %h/%h required all 0",
               u_busy, s_busy, u_done, s_done, u_result, s_result, u_max, s_max);
    end
    dones = 0;
    for (int n = 0; n < LANES + 3; n++) begin
      @(negedge clk);
      if (n == 1) rst_n = 1'b1;
      if (u_done || s_done) dones++;
    end
    tests_run++;
    if (dones != 0) begin
      tests_failed++;
      $display("FAIL reset_no_done: got %0d pulses required 0", dones);
    end
    run_dot("after_reset", 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_clear_max();
    test_back_to_back();
    test_random();
    test_reset_mid_mac();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
